seq_generator: RTL and testbench
================================

SEQ_GENERATOR -- requirements
Module: seq_generator

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the frame length in bits.
REQ-002 Parameter GAP, default 1, SHALL set the number of idle bit slots inserted after each frame (0 allowed).
REQ-003 clk  input  1  SHALL be the single clock; all state updates occur on the rising edge.
REQ-004 reset  input  1  SHALL be a synchronous, active-high reset.
REQ-005 in_data  input  WIDTH  SHALL carry the parallel word to serialise.
REQ-006 in_valid  input  1  SHALL indicate that in_data is valid.
REQ-007 in_ready  output  1  SHALL be high only in IDLE with reset low.
REQ-008 out  output  1  SHALL carry the serial bit, MSB first, held low when bit_valid is low.
REQ-009 bit_valid  output  1  SHALL be high while out carries a frame bit.
REQ-010 frame_start  output  1  SHALL pulse with the first bit of each frame, usable as the detector's frame reset.
REQ-011 frame_done  output  1  SHALL pulse with the last bit of each frame.
REQ-012 exp_match  output  1  SHALL be high while the bit on out completes a 1010 pattern within the current frame.
REQ-013 match_count  output  4  SHALL hold the running count of 1010 matches in the current frame; it is final while frame_done is high.

Function
REQ-014 The FSM SHALL have three one-hot states: IDLE, SHIFT and GAPW.
REQ-015 A handshake SHALL occur at a rising edge where in_valid and in_ready are both high; in_data is captured at that edge.
REQ-016 At the handshake edge the state SHALL become SHIFT, with out=in_data[WIDTH-1], bit_valid=1 and frame_start=1, so the first bit appears one cycle after the edge.
REQ-017 Each subsequent edge in SHIFT SHALL present the next lower bit; bit i (1-based) is driven for exactly one cycle.
REQ-018 frame_done SHALL be high in the same cycle as bit WIDTH; frame_start and frame_done are single-cycle pulses.
REQ-019 On the edge after bit WIDTH, the block SHALL enter GAPW for GAP cycles (or IDLE directly if GAP=0), with bit_valid=0 and out=0.
REQ-020 After GAPW the block SHALL enter IDLE; with in_valid held high, frame_start pulses SHALL be spaced exactly WIDTH+GAP+1 cycles apart.
REQ-021 in_valid outside IDLE SHALL be ignored, and in_data SHALL not be re-sampled mid-frame.
REQ-022 The pattern tracker SHALL use five states, DEF, P1, P10, P101 and P1010, with the following transitions:
- DEF: on 1 go to P1, on 0 stay in DEF.
- P1: on 1 stay in P1, on 0 go to P10.
- P10: on 1 go to P101, on 0 go to DEF.
- P101: on 1 go to P1, on 0 go to P1010.
- P1010: on 1 go to P101, on 0 go to DEF.
REQ-023 The tracker SHALL be forced to DEF before bit 1 of every frame, so matches never span frames.
REQ-024 exp_match SHALL be registered and aligned with out; it is 1 exactly when the tracker enters P1010 on that bit (overlapping matches count).
REQ-025 match_count SHALL clear at frame_start and increment with each exp_match; it cannot wrap, since the maximum is WIDTH/2-1 for WIDTH≤16.
REQ-026 match_count SHALL hold its value through GAPW and IDLE until the next frame_start.

Reset
REQ-027 While reset is high at an edge, the state SHALL become IDLE, the tracker DEF, and out, bit_valid, frame_start, frame_done, exp_match and match_count SHALL all be 0; in_ready SHALL be 0 while reset is high.
REQ-028 Reset mid-frame SHALL abort the frame with no frame_done; in_ready SHALL be 1 in the first cycle after reset deasserts.
REQ-029 Reset SHALL take priority over a simultaneous handshake, and the word SHALL be dropped.

Structure
REQ-030 A shared package seq_defs SHALL hold the FSM one-hot encodings (IDLE, SHIFT, GAPW), the tracker encodings (DEF, P1, P10, P101, P1010) and the pattern constant 4'b1010.
REQ-031 Tracker next-state and match logic SHALL live in a sub-module, seq_pattern_tracker, that is combinational and reusable by the detector's checker.

Verification
REQ-032 Word 8'b10101010 -> out sequence 1,0,1,0,1,0,1,0; exp_match high on bits 4, 6 and 8; match_count=3 at frame_done.
REQ-033 Word 8'b11010010 -> exp_match high on bit 5 only; match_count=1.
REQ-034 Word 8'b00000000 -> exp_match never high; match_count=0; frame_done on bit 8.
REQ-035 Back-to-back frames with GAP=1, 8'b00000101 then 8'b01110000, in_valid held high:
- frame_start pulses are 10 cycles apart;
- frame 2 bit 1 shows no exp_match;
- match_count=0 for both frames.
REQ-036 Reset asserted for one cycle during bit 3 -> next cycle has bit_valid=0 and out=0, with no frame_done; in_ready=1 afterwards; the following word serialises correctly.
REQ-037 in_valid pulsed during SHIFT -> in_ready=0, the word is ignored, and the output stream is unchanged.

Source files
------------

// File: rtl/seq_defs.sv
// rtl/seq_defs.sv - shared encodings for the serialiser FSM and the 1010 pattern tracker
package seq_defs;

    typedef enum logic [2:0] {
        IDLE  = 3'b001,
        SHIFT = 3'b010,
        GAPW  = 3'b100
    } seq_state_t;

    typedef enum logic [2:0] {
        DEF   = 3'd0,
        P1    = 3'd1,
        P10   = 3'd2,
        P101  = 3'd3,
        P1010 = 3'd4
    } trk_state_t;

    localparam logic [3:0] PATTERN = 4'b1010;

endpackage

// File: rtl/seq_pattern_tracker.sv
// rtl/seq_pattern_tracker.sv - combinational next-state and match logic for overlapping 1010 detection
module seq_pattern_tracker
    import seq_defs::*;
(
    input  trk_state_t state,
    input  logic       din,
    output trk_state_t next_state,
    output logic       match
);

    always_comb begin
        next_state = DEF;
        unique case (state)
            DEF:     next_state = din ? P1   : DEF;
            P1:      next_state = din ? P1   : P10;
            P10:     next_state = din ? P101 : DEF;
            P101:    next_state = din ? P1   : P1010;
            P1010:   next_state = din ? P101 : DEF;
            default: next_state = DEF;
        endcase
    end

    // P101 followed by the final pattern bit is the only way into P1010
    assign match = (state == P101) && (din == PATTERN[0]);

endmodule

// File: rtl/seq_generator.sv
// rtl/seq_generator.sv - MSB-first frame serialiser with inter-frame gap and per-frame 1010 match counting
module seq_generator
    import seq_defs::*;
#(
    parameter int WIDTH = 8,
    parameter int GAP   = 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic             out,
    output logic             bit_valid,
    output logic             frame_start,
    output logic             frame_done,
    output logic             exp_match,
    output logic [3:0]       match_count
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam int GW = (GAP > 1) ? $clog2(GAP) : 1;

    seq_state_t       state, state_d;
    trk_state_t       trk, trk_d, trk_in, trk_next;
    logic [WIDTH-1:0] shreg, shreg_d;
    logic [CW-1:0]    cnt, cnt_d;
    logic [GW-1:0]    gap, gap_d;
    logic             trk_din, trk_match;
    logic             out_d, bit_valid_d, frame_start_d, frame_done_d, exp_match_d;
    logic [3:0]       match_count_d;

    assign in_ready = (state == IDLE) && !reset;

    // The tracker always restarts from DEF on the first bit of a frame
    assign trk_in  = (state == IDLE) ? DEF : trk;
    assign trk_din = (state == IDLE) ? in_data[WIDTH-1] : shreg[WIDTH-1];

    seq_pattern_tracker u_tracker (
        .state      (trk_in),
        .din        (trk_din),
        .next_state (trk_next),
        .match      (trk_match)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= IDLE;
            trk         <= DEF;
            shreg       <= '0;
            cnt         <= '0;
            gap         <= '0;
            out         <= 1'b0;
            bit_valid   <= 1'b0;
            frame_start <= 1'b0;
            frame_done  <= 1'b0;
            exp_match   <= 1'b0;
            match_count <= 4'd0;
        end else begin
            state       <= state_d;
            trk         <= trk_d;
            shreg       <= shreg_d;
            cnt         <= cnt_d;
            gap         <= gap_d;
            out         <= out_d;
            bit_valid   <= bit_valid_d;
            frame_start <= frame_start_d;
            frame_done  <= frame_done_d;
            exp_match   <= exp_match_d;
            match_count <= match_count_d;
        end
    end

    always_comb begin
        state_d       = state;
        trk_d         = trk;
        shreg_d       = shreg;
        cnt_d         = cnt;
        gap_d         = gap;
        out_d         = 1'b0;
        bit_valid_d   = 1'b0;
        frame_start_d = 1'b0;
        frame_done_d  = 1'b0;
        exp_match_d   = 1'b0;
        match_count_d = match_count;
        unique case (state)
            IDLE: begin
                if (in_valid) begin
                    state_d       = SHIFT;
                    shreg_d       = in_data << 1;
                    cnt_d         = CW'(1);
                    out_d         = in_data[WIDTH-1];
                    bit_valid_d   = 1'b1;
                    frame_start_d = 1'b1;
                    frame_done_d  = (WIDTH == 1);
                    trk_d         = trk_next;
                    exp_match_d   = trk_match;
                    match_count_d = {3'b000, trk_match};
                end
            end
            SHIFT: begin
                if (cnt == CW'(WIDTH)) begin
                    trk_d = DEF;
                    if (GAP == 0) begin
                        state_d = IDLE;
                    end else begin
                        state_d = GAPW;
                        gap_d   = GW'(GAP - 1);
                    end
                end else begin
                    out_d         = shreg[WIDTH-1];
                    shreg_d       = shreg << 1;
                    cnt_d         = cnt + CW'(1);
                    bit_valid_d   = 1'b1;
                    frame_done_d  = (cnt + CW'(1)) == CW'(WIDTH);
                    trk_d         = trk_next;
                    exp_match_d   = trk_match;
                    match_count_d = match_count + {3'b000, trk_match};
                end
            end
            GAPW: begin
                if (gap == '0) state_d = IDLE;
                else            gap_d   = gap - GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: tb/tb_seq_generator.sv
// tb/tb_seq_generator.sv - randomized self-checking bench for seq_generator against a substring-match model
module tb_seq_generator;

    localparam int W = 8;
    localparam int G = 1;

    logic         clk = 1'b0;
    logic         reset;
    logic [W-1:0] in_data;
    logic         in_valid;
    logic         in_ready;
    logic         out;
    logic         bit_valid;
    logic         frame_start;
    logic         frame_done;
    logic         exp_match;
    logic [3:0]   match_count;

    int total_cnt = 0;
    int pass_cnt  = 0;

    seq_generator #(.WIDTH(W), .GAP(G)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out         (out),
        .bit_valid   (bit_valid),
        .frame_start (frame_start),
        .frame_done  (frame_done),
        .exp_match   (exp_match),
        .match_count (match_count)
    );

    always #5 clk = ~clk;

    // Bit i (1-based, MSB first) completes a match when bits i-3..i of the frame read 1010
    function automatic logic [W:1] model_match(input logic [W-1:0] w);
        logic [W:1] m;
        logic [3:0] win;
        m = '0;
        for (int i = 4; i <= W; i++) begin
            win = {w[W-i+3], w[W-i+2], w[W-i+1], w[W-i]};
            m[i] = (win == 4'b1010);
        end
        return m;
    endfunction

    function automatic logic [8:0] observed();
        return {out, bit_valid, frame_start, frame_done, exp_match, match_count};
    endfunction

    task automatic run_frame(input logic [W-1:0] w, input int pulse_at);
        logic [W:1] m;
        logic [8:0] expv;
        int cnt = 0;
        int waited = 0;
        m = model_match(w);
        while (in_ready !== 1'b1 && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL ready_wait: in_ready=%b required 1", in_ready);
        else pass_cnt++;
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = W'($urandom);
        for (int i = 1; i <= W; i++) begin
            cnt += int'(m[i]);
            expv = {w[W-i], 1'b1, (i == 1), (i == W), m[i], 4'(cnt)};
            total_cnt++;
            if (observed() !== expv)
                $display("FAIL frame_bit word=%b bit=%0d: got %b required %b", w, i, observed(), expv);
            else pass_cnt++;
            if (i == pulse_at) begin
                total_cnt++;
                if (in_ready !== 1'b0) $display("FAIL ready_in_shift: in_ready=%b required 0", in_ready);
                else pass_cnt++;
                in_valid = 1'b1;
                in_data  = ~w;
            end else begin
                in_valid = 1'b0;
            end
            if (i < W) @(negedge clk);
        end
        in_valid = 1'b0;
        for (int g = 0; g < G; g++) begin
            @(negedge clk);
            total_cnt++;
            if (observed() !== {5'b00000, 4'(cnt)})
                $display("FAIL gap_slot word=%b: got %b required %b", w, observed(), {5'b00000, 4'(cnt)});
            else pass_cnt++;
        end
        @(negedge clk);
        total_cnt++;
        if ({in_ready, bit_valid, match_count} !== {2'b10, 4'(cnt)})
            $display("FAIL idle_after_frame word=%b: got %b required %b",
                     w, {in_ready, bit_valid, match_count}, {2'b10, 4'(cnt)});
        else pass_cnt++;
    endtask

    task automatic test_reset();
        reset    = 1'b1;
        in_valid = 1'b1;
        in_data  = 8'b10101010;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({in_ready, observed()} !== 10'd0)
            $display("FAIL reset_state: got %b required 0", {in_ready, observed()});
        else pass_cnt++;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL ready_after_reset: in_ready=%b required 1", in_ready);
        else pass_cnt++;
        @(negedge clk);
        total_cnt++;
        if (bit_valid !== 1'b0) $display("FAIL word_dropped_under_reset: bit_valid=%b required 0", bit_valid);
        else pass_cnt++;
    endtask

    task automatic test_directed();
        run_frame(8'b10101010, 0);
        run_frame(8'b11010010, 0);
        run_frame(8'b00000000, 0);
    endtask

    task automatic test_ignore_valid();
        run_frame(8'b10110100, 3);
        run_frame(8'b01010110, 7);
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++)
            run_frame(W'($urandom), (n % 3 == 0) ? int'($urandom_range(1, W)) : 0);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] words [2];
        logic [W-1:0] cur;
        logic [W:1]   m;
        logic [8:0]   expv;
        int starts [2];
        int fidx = -1;
        int bitn = W;
        int cnt  = 0;
        words[0] = 8'b00000101;
        words[1] = 8'b01110000;
        starts[0] = 0;
        starts[1] = 0;
        cur = words[0];
        m   = '0;
        in_valid = 1'b1;
        in_data  = words[0];
        for (int cyc = 0; cyc < 40 && !(fidx == 1 && bitn == W); cyc++) begin
            @(negedge clk);
            if (frame_start === 1'b1 && fidx < 1) begin
                fidx++;
                starts[fidx] = cyc;
                bitn = 0;
                cnt  = 0;
                cur  = words[fidx];
                m    = model_match(cur);
                in_data = words[1];
            end
            if (fidx >= 0 && bitn < W) begin
                bitn++;
                cnt += int'(m[bitn]);
                expv = {cur[W-bitn], 1'b1, (bitn == 1), (bitn == W), m[bitn], 4'(cnt)};
                total_cnt++;
                if (observed() !== expv)
                    $display("FAIL b2b_bit frame=%0d bit=%0d: got %b required %b", fidx, bitn, observed(), expv);
                else pass_cnt++;
            end else if (fidx >= 0) begin
                total_cnt++;
                if (bit_valid !== 1'b0) $display("FAIL b2b_gap: bit_valid=%b required 0", bit_valid);
                else pass_cnt++;
            end
        end
        in_valid = 1'b0;
        total_cnt++;
        if (fidx != 1 || starts[1] - starts[0] != W + G + 1)
            $display("FAIL b2b_spacing: frames=%0d spacing=%0d required 2 frames spaced %0d",
                     fidx + 1, starts[1] - starts[0], W + G + 1);
        else pass_cnt++;
        repeat (G + 1) @(negedge clk);
    endtask

    task automatic test_reset_mid_frame();
        logic [W-1:0] w;
        w = 8'b11100110;
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (2) @(negedge clk);
        total_cnt++;
        if ({out, bit_valid} !== {w[W-3], 1'b1})
            $display("FAIL mid_bit3: got %b required %b", {out, bit_valid}, {w[W-3], 1'b1});
        else pass_cnt++;
        reset = 1'b1;
        @(negedge clk);
        total_cnt++;
        if ({in_ready, observed()} !== 10'd0)
            $display("FAIL mid_reset_outputs: got %b required 0", {in_ready, observed()});
        else pass_cnt++;
        reset = 1'b0;
        #1;
        total_cnt++;
        if (in_ready !== 1'b1) $display("FAIL mid_reset_ready: in_ready=%b required 1", in_ready);
        else pass_cnt++;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            total_cnt++;
            if ({frame_done, bit_valid} !== 2'b00)
                $display("FAIL aborted_frame_activity cycle=%0d: got %b required 00", k, {frame_done, bit_valid});
            else pass_cnt++;
        end
        run_frame(W'($urandom), 0);
    endtask

    initial begin
        reset    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        test_reset();
        test_directed();
        test_ignore_valid();
        test_back_to_back();
        test_reset_mid_frame();
        test_random();
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
